// File: rtl/fwd_sel_if.sv
// Decode-side hazard bus between the D stage and the forwarding/stall controller.
// The D stage drives the source and destination fields, and the controller returns the stall and the mux selects.
interface fwd_sel_if #(
   parameter int TW = 2
);
   logic [4:0]    d_rs;
   logic [4:0]    d_rt;
   logic [TW-1:0] d_tuse_rs;
   logic [TW-1:0] d_tuse_rt;
   logic          d_wr_en;
   logic [4:0]    d_wr_addr;
   logic [TW-1:0] d_tnew;
   logic          stall;
   logic [1:0]    d_rs_sel;
   logic [1:0]    d_rt_sel;
   logic [1:0]    e_rs_sel;
   logic [1:0]    e_rt_sel;

   modport master (
      output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wr_addr, d_tnew,
      input  stall, d_rs_sel, d_rt_sel, e_rs_sel, e_rt_sel
   );

   modport slave (
      input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wr_en, d_wr_addr, d_tnew,
      output stall, d_rs_sel, d_rt_sel, e_rs_sel, e_rt_sel
   );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// Hazard controller: tracks in-flight writes in E/M/W with Tnew countdowns and derives the
// D-stage stall plus the forwarding selects for the D-stage compare and E-stage ALU operands.
module fwd_sel_ctrl #(
   parameter int TW = 2
) (
   input logic       clk,
   input logic       reset,
   fwd_sel_if.slave  bus
);
   logic          e_vld_q, e_vld_d;
   logic [4:0]    e_addr_q, e_addr_d;
   logic [TW-1:0] e_tnew_q, e_tnew_d;
   logic          m_vld_q, m_vld_d;
   logic [4:0]    m_addr_q, m_addr_d;
   logic [TW-1:0] m_tnew_q, m_tnew_d;
   logic          w_vld_q, w_vld_d;
   logic [4:0]    w_addr_q, w_addr_d;
   logic [4:0]    e_rs_q, e_rs_d;
   logic [4:0]    e_rt_q, e_rt_d;
   logic          stall_s;

   // A non-zero address match on a valid record; $0 can never match.
   function automatic logic rec_hit(input logic vld, input logic [4:0] addr, input logic [4:0] src);
      return vld && (addr != 5'd0) && (addr == src);
   endfunction

   // The nearest ready stage wins: M only when its result exists, otherwise W.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic m_vld, input logic [4:0] m_addr,
                                          input logic [TW-1:0] m_tnew,
                                          input logic w_vld, input logic [4:0] w_addr);
      logic [1:0] sel;
      sel = 2'b00;
      if (rec_hit(m_vld, m_addr, src) && (m_tnew == {TW{1'b0}})) begin
         sel = 2'b01;
      end else if (rec_hit(w_vld, w_addr, src)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Stall when an E or M producer of a D source will not be ready by the time the source is used.
   always_comb begin
      stall_s = 1'b0;
      if ((rec_hit(e_vld_q, e_addr_q, bus.d_rs) && (e_tnew_q > bus.d_tuse_rs)) ||
          (rec_hit(m_vld_q, m_addr_q, bus.d_rs) && (m_tnew_q > bus.d_tuse_rs)) ||
          (rec_hit(e_vld_q, e_addr_q, bus.d_rt) && (e_tnew_q > bus.d_tuse_rt)) ||
          (rec_hit(m_vld_q, m_addr_q, bus.d_rt) && (m_tnew_q > bus.d_tuse_rt))) begin
         stall_s = 1'b1;
      end else begin
         stall_s = 1'b0;
      end
   end

   // Forwarding selects for the D compare and E ALU operands.
   always_comb begin
      bus.stall    = stall_s;
      bus.d_rs_sel = fwd_sel(bus.d_rs, m_vld_q, m_addr_q, m_tnew_q, w_vld_q, w_addr_q);
      bus.d_rt_sel = fwd_sel(bus.d_rt, m_vld_q, m_addr_q, m_tnew_q, w_vld_q, w_addr_q);
      bus.e_rs_sel = fwd_sel(e_rs_q, m_vld_q, m_addr_q, m_tnew_q, w_vld_q, w_addr_q);
      bus.e_rt_sel = fwd_sel(e_rt_q, m_vld_q, m_addr_q, m_tnew_q, w_vld_q, w_addr_q);
   end

   // Pipeline advance: M and W always shift, and E takes either the D instruction or a bubble.
   always_comb begin
      w_vld_d  = m_vld_q;
      w_addr_d = m_addr_q;
      m_vld_d  = e_vld_q;
      m_addr_d = e_addr_q;
      m_tnew_d = (e_tnew_q == {TW{1'b0}}) ? {TW{1'b0}} : (e_tnew_q - TW'(1));
      e_vld_d  = bus.d_wr_en;
      e_addr_d = bus.d_wr_addr;
      e_tnew_d = bus.d_tnew;
      e_rs_d   = bus.d_rs;
      e_rt_d   = bus.d_rt;
      if (stall_s) begin
         e_vld_d  = 1'b0;
         e_addr_d = 5'd0;
         e_tnew_d = {TW{1'b0}};
         e_rs_d   = 5'd0;
         e_rt_d   = 5'd0;
      end else begin
         e_vld_d  = bus.d_wr_en;
         e_addr_d = bus.d_wr_addr;
      end
   end

   // Stage record registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_vld_q  <= 1'b0;
         e_addr_q <= 5'd0;
         e_tnew_q <= {TW{1'b0}};
         m_vld_q  <= 1'b0;
         m_addr_q <= 5'd0;
         m_tnew_q <= {TW{1'b0}};
         w_vld_q  <= 1'b0;
         w_addr_q <= 5'd0;
         e_rs_q   <= 5'd0;
         e_rt_q   <= 5'd0;
      end else begin
         e_vld_q  <= e_vld_d;
         e_addr_q <= e_addr_d;
         e_tnew_q <= e_tnew_d;
         m_vld_q  <= m_vld_d;
         m_addr_q <= m_addr_d;
         m_tnew_q <= m_tnew_d;
         w_vld_q  <= w_vld_d;
         w_addr_q <= w_addr_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
      end
   end
endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Self-checking bench for fwd_sel_ctrl: directed hazard scenarios plus random traffic
// compared against an age-based model of in-flight producers.
module tb_fwd_sel_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fwd_sel_if #(.TW(2)) bus ();
   fwd_sel_ctrl #(.TW(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   // Model: slot k holds the producer that entered E k cycles ago (0=E, 1=M, 2=W) with its original Tnew.
   bit mv[3];
   int ma[3];
   int mt[3];
   int mers, mert;

   function automatic int remaining(int age);
      return (mt[age] > age) ? mt[age] - age : 0;
   endfunction

   function automatic bit live(int age, int s);
      return mv[age] && (s != 0) && (ma[age] == s);
   endfunction

   function automatic bit model_stall();
      bit st = 1'b0;
      for (int age = 0; age < 2; age++) begin
         if (live(age, int'(bus.d_rs)) && remaining(age) > int'(bus.d_tuse_rs)) st = 1'b1;
         if (live(age, int'(bus.d_rt)) && remaining(age) > int'(bus.d_tuse_rt)) st = 1'b1;
      end
      return st;
   endfunction

   function automatic int model_sel(int s);
      if (live(1, s) && remaining(1) == 0) return 1;
      if (live(2, s)) return 2;
      return 0;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         mv[k] = 1'b0; ma[k] = 0; mt[k] = 0;
      end
      mers = 0; mert = 0;
   endtask

   task automatic model_advance(bit st);
      mv[2] = mv[1]; ma[2] = ma[1]; mt[2] = mt[1];
      mv[1] = mv[0]; ma[1] = ma[0]; mt[1] = mt[0];
      if (st) begin
         mv[0] = 1'b0; ma[0] = 0; mt[0] = 0; mers = 0; mert = 0;
      end else begin
         mv[0] = bus.d_wr_en; ma[0] = int'(bus.d_wr_addr); mt[0] = int'(bus.d_tnew);
         mers = int'(bus.d_rs); mert = int'(bus.d_rt);
      end
   endtask

   task automatic tick();
      bit st;
      st = model_stall();
      @(posedge clk);
      model_advance(st);
      #1;
   endtask

   task automatic drive(int rs, int rt, int tur, int tut, bit we, int wa, int tn);
      bus.d_rs = 5'(rs); bus.d_rt = 5'(rt);
      bus.d_tuse_rs = 2'(tur); bus.d_tuse_rt = 2'(tut);
      bus.d_wr_en = we; bus.d_wr_addr = 5'(wa); bus.d_tnew = 2'(tn);
   endtask

   task automatic flush();
      drive(0, 0, 0, 0, 1'b0, 0, 0);
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 1'b0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      checks++;
      if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", bus.stall); end
      checks++;
      if ({bus.d_rs_sel, bus.d_rt_sel, bus.e_rs_sel, bus.e_rt_sel} !== 8'h00) begin
         errors++; $display("FAIL reset_sels: got %h expected 00", {bus.d_rs_sel, bus.d_rt_sel, bus.e_rs_sel, bus.e_rt_sel});
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_alu_raw();
      flush();
      drive(0, 0, 0, 0, 1'b1, 8, 1);
      tick();
      drive(8, 0, 1, 1, 1'b0, 0, 0);
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin errors++; $display("FAIL alu_raw_stall: got %0b expected 0", bus.stall); end
      tick();
      checks++;
      if (bus.e_rs_sel !== 2'b01) begin errors++; $display("FAIL alu_raw_e_rs_sel: got %b expected 01", bus.e_rs_sel); end
   endtask

   task automatic test_load_use();
      flush();
      drive(0, 0, 0, 0, 1'b1, 9, 2);
      tick();
      drive(0, 9, 1, 1, 1'b0, 0, 0);
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall1: got %0b expected 1", bus.stall); end
      tick();
      checks++;
      if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_use_stall2: got %0b expected 0", bus.stall); end
      tick();
      drive(0, 0, 0, 0, 1'b0, 0, 0);
      #1;
      checks++;
      if (bus.e_rt_sel !== 2'b10) begin errors++; $display("FAIL load_use_e_rt_sel: got %b expected 10", bus.e_rt_sel); end
   endtask

   task automatic test_branch();
      flush();
      drive(0, 0, 0, 0, 1'b1, 4, 1);
      tick();
      drive(4, 0, 0, 0, 1'b0, 0, 0);
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin errors++; $display("FAIL branch_stall1: got %0b expected 1", bus.stall); end
      tick();
      checks++;
      if (bus.stall !== 1'b0) begin errors++; $display("FAIL branch_stall2: got %0b expected 0", bus.stall); end
      checks++;
      if (bus.d_rs_sel !== 2'b01) begin errors++; $display("FAIL branch_d_rs_sel: got %b expected 01", bus.d_rs_sel); end
   endtask

   task automatic test_back_to_back();
      flush();
      drive(0, 0, 0, 0, 1'b1, 5, 0);
      tick();
      tick();
      drive(5, 0, 1, 1, 1'b0, 0, 0);
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0b expected 0", bus.stall); end
      tick();
      checks++;
      if (bus.e_rs_sel !== 2'b01) begin errors++; $display("FAIL b2b_e_rs_sel: got %b expected 01", bus.e_rs_sel); end
   endtask

   task automatic test_zero_reg();
      flush();
      drive(0, 0, 0, 0, 1'b1, 0, 2);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 1'b1, 0, 2);
         #1;
         checks++;
         if (bus.stall !== 1'b0 || {bus.d_rs_sel, bus.d_rt_sel, bus.e_rs_sel, bus.e_rt_sel} !== 8'h00) begin
            errors++;
            $display("FAIL zero_reg: got stall=%0b sels=%h expected stall=0 sels=00", bus.stall,
                     {bus.d_rs_sel, bus.d_rt_sel, bus.e_rs_sel, bus.e_rt_sel});
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_stall();
      flush();
      drive(0, 0, 0, 0, 1'b1, 4, 1);
      tick();
      drive(4, 0, 0, 0, 1'b0, 0, 0);
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %0b expected 1", bus.stall); end
      reset = 1'b1;
      #1;
      model_clear();
      checks++;
      if (bus.stall !== 1'b0 || {bus.d_rs_sel, bus.d_rt_sel, bus.e_rs_sel, bus.e_rt_sel} !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_async: got stall=%0b sels=%h expected stall=0 sels=00", bus.stall,
                  {bus.d_rs_sel, bus.d_rt_sel, bus.e_rs_sel, bus.e_rt_sel});
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_mid_issue: got %0b expected 0", bus.stall); end
      tick();
      checks++;
      if (bus.e_rs_sel !== 2'b00 || bus.stall !== 1'b0) begin
         errors++; $display("FAIL rst_mid_after: got sel=%b stall=%0b expected 00 and 0", bus.e_rs_sel, bus.stall);
      end
   endtask

   task automatic test_random();
      bit held = 1'b0;
      flush();
      for (int i = 0; i < 500; i++) begin
         if (!held) begin
            drive($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0), $urandom_range(2, 0),
                  1'($urandom_range(1, 0)), $urandom_range(3, 0), $urandom_range(2, 0));
         end
         #1;
         checks++;
         if (bus.stall !== model_stall()) begin
            errors++; $display("FAIL rnd_stall cyc %0d: got %0b expected %0b", i, bus.stall, model_stall());
         end
         checks++;
         if (int'(bus.d_rs_sel) != model_sel(int'(bus.d_rs)) || int'(bus.d_rt_sel) != model_sel(int'(bus.d_rt))) begin
            errors++; $display("FAIL rnd_d_sel cyc %0d: got %b/%b expected %0d/%0d", i, bus.d_rs_sel, bus.d_rt_sel,
                               model_sel(int'(bus.d_rs)), model_sel(int'(bus.d_rt)));
         end
         checks++;
         if (int'(bus.e_rs_sel) != model_sel(mers) || int'(bus.e_rt_sel) != model_sel(mert)) begin
            errors++; $display("FAIL rnd_e_sel cyc %0d: got %b/%b expected %0d/%0d", i, bus.e_rs_sel, bus.e_rt_sel,
                               model_sel(mers), model_sel(mert));
         end
         held = model_stall();
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_alu_raw();
      test_load_use();
      test_branch();
      test_back_to_back();
      test_zero_reg();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
